// File: rtl/alu_scan_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU mutation scanner.
package alu_scan_pkg;

  localparam int unsigned OPND_W    = 4;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned VEC_IDX_W = 11;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned SETTLE_W  = 3;
  localparam int unsigned MASK_W    = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd5;
  localparam logic [OP_W-1:0] OP_LT  = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Lowest enabled opcode above cur_op (or equal when incl); MSB flags that one exists.
  function automatic logic [OP_W:0] find_op(input logic [MASK_W-1:0] mask,
                                            input logic [OP_W-1:0]   cur_op,
                                            input logic              incl);
    logic [OP_W:0] res;
    res = '0;
    for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur_op)) || (incl && (i == int'(cur_op))))) begin
        res = {1'b1, OP_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference 4-bit ALU used to judge the ALU under test.
module alu_golden_model
  import alu_scan_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [OPND_W-1:0] exp_result_c,
  output logic              exp_zero_c
);

  always_comb begin
    exp_result_c = '0;
    case (op_i)
      OP_ADD:  exp_result_c = a_i + b_i;
      OP_SUB:  exp_result_c = a_i - b_i;
      OP_AND:  exp_result_c = a_i & b_i;
      OP_OR:   exp_result_c = a_i | b_i;
      OP_XOR:  exp_result_c = a_i ^ b_i;
      OP_EQ:   exp_result_c = (a_i == b_i) ? OPND_W'(1) : '0;
      OP_LT:   exp_result_c = (a_i < b_i) ? OPND_W'(1) : '0;
      OP_NOP:  exp_result_c = '0;
      default: exp_result_c = '0;
    endcase
  end

  assign exp_zero_c = (exp_result_c == '0);

endmodule

// File: rtl/alu_mutation_scanner.sv
// Sweeps an external ALU through every enabled {op,A,B} vector and compares it to a golden model.
// Define ALU_SCAN_ZERO_CHECK_EN to also compare the ALU zero flag.
module alu_mutation_scanner
  import alu_scan_pkg::*;
#(
  parameter int unsigned       SETTLE       = 0,
  parameter logic [MASK_W-1:0] OPMASK       = 8'hFF,
  parameter bit                STOP_ON_KILL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              killed,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [OPND_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [OPND_W-1:0] fail_a,
  output logic [OPND_W-1:0] fail_b,
  output logic [OP_W-1:0]   fail_op,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  state_e              state_q;
  logic                busy_q, done_q, killed_q;
  logic [OPND_W-1:0]   a_q, b_q, fail_a_q, fail_b_q;
  logic [OP_W-1:0]     op_q, fail_op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SETTLE_W-1:0] settle_q;

  logic [OPND_W-1:0]   exp_result_c;
  logic                exp_zero_c;
  logic                mismatch_c;
  logic [OP_W:0]       first_op_c, next_op_c;
  logic                sample_c, last_vec_c, stop_c;
  logic [OPND_W-1:0]   a_d, b_d;
  logic [OP_W-1:0]     op_d;

  alu_golden_model u_golden (
    .a_i          (a_q),
    .b_i          (b_q),
    .op_i         (op_q),
    .exp_result_c (exp_result_c),
    .exp_zero_c   (exp_zero_c)
  );

`ifdef ALU_SCAN_ZERO_CHECK_EN
  assign mismatch_c = (alu_result != exp_result_c) || (alu_zero != exp_zero_c);
`else
  logic unused_zero_c;
  assign unused_zero_c = alu_zero ^ exp_zero_c;
  assign mismatch_c    = (alu_result != exp_result_c);
`endif

  assign first_op_c = find_op(OPMASK, '0, 1'b1);
  assign next_op_c  = find_op(OPMASK, op_q, 1'b0);
  assign sample_c   = (settle_q == SETTLE_W'(SETTLE));
  assign last_vec_c = (a_q == '1) && (b_q == '1) && !next_op_c[OP_W];
  assign stop_c     = last_vec_c || (mismatch_c && STOP_ON_KILL);

  // Next vector in {op, A, B} ascending order; disabled opcodes are jumped over directly.
  always_comb begin
    b_d  = b_q + OPND_W'(1);
    a_d  = a_q;
    op_d = op_q;
    if (b_q == '1) begin
      a_d = a_q + OPND_W'(1);
      if (a_q == '1) begin
        op_d = next_op_c[OP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      killed_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_op_q <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            killed_q  <= 1'b0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_op_q <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= first_op_c[OP_W-1:0];
            if (first_op_c[OP_W]) begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (!sample_c) begin
            settle_q <= settle_q + SETTLE_W'(1);
          end else begin
            settle_q <= '0;
            if (mismatch_c) begin
              cnt_q    <= cnt_q + CNT_W'(1);
              killed_q <= 1'b1;
              if (!killed_q) begin
                fail_a_q  <= a_q;
                fail_b_q  <= b_q;
                fail_op_q <= op_q;
              end
            end
            if (stop_c) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              a_q  <= a_d;
              b_q  <= b_d;
              op_q <= op_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign killed       = killed_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign fail_a       = fail_a_q;
  assign fail_b       = fail_b_q;
  assign fail_op      = fail_op_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_alu_mutation_scanner.sv
// Bench: seven scanner configurations run side by side against correct and mutant ALUs.
module tb_alu_mutation_scanner;

  localparam int NI = 7;
  localparam logic [NI-1:0] MUT = 7'b0001110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, rst5, start5;
  logic       busy_w[NI], done_w[NI], killed_w[NI], zero_w[NI];
  logic [3:0] a_w[NI], b_w[NI], res_w[NI], fa_w[NI], fb_w[NI];
  logic [2:0] op_w[NI], fop_w[NI];
  logic [11:0] cnt_w[NI];

  function automatic logic [3:0] gold(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a == b) ? 4'd1 : 4'd0;
      3'd6: return (a < b) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  // ALUs under test: mutants compute B+B for ADD; instance 4 has its zero flag stuck at 0.
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      logic [3:0] r;
      r = gold(op_w[i], a_w[i], b_w[i]);
      if (MUT[i] && op_w[i] == 3'd0) r = b_w[i] + b_w[i];
      res_w[i]  = r;
      zero_w[i] = (i == 4) ? 1'b0 : (r == 4'd0);
    end
  end

  alu_mutation_scanner u0 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .killed(killed_w[0]), .alu_a(a_w[0]), .alu_b(b_w[0]), .alu_op(op_w[0]), .alu_result(res_w[0]),
    .alu_zero(zero_w[0]), .fail_a(fa_w[0]), .fail_b(fb_w[0]), .fail_op(fop_w[0]), .mismatch_cnt(cnt_w[0]));
  alu_mutation_scanner #(.STOP_ON_KILL(1'b1)) u1 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[1]),
    .done(done_w[1]), .killed(killed_w[1]), .alu_a(a_w[1]), .alu_b(b_w[1]), .alu_op(op_w[1]),
    .alu_result(res_w[1]), .alu_zero(zero_w[1]), .fail_a(fa_w[1]), .fail_b(fb_w[1]), .fail_op(fop_w[1]),
    .mismatch_cnt(cnt_w[1]));
  alu_mutation_scanner #(.STOP_ON_KILL(1'b0)) u2 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[2]),
    .done(done_w[2]), .killed(killed_w[2]), .alu_a(a_w[2]), .alu_b(b_w[2]), .alu_op(op_w[2]),
    .alu_result(res_w[2]), .alu_zero(zero_w[2]), .fail_a(fa_w[2]), .fail_b(fb_w[2]), .fail_op(fop_w[2]),
    .mismatch_cnt(cnt_w[2]));
  alu_mutation_scanner #(.OPMASK(8'hFE)) u3 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[3]),
    .done(done_w[3]), .killed(killed_w[3]), .alu_a(a_w[3]), .alu_b(b_w[3]), .alu_op(op_w[3]),
    .alu_result(res_w[3]), .alu_zero(zero_w[3]), .fail_a(fa_w[3]), .fail_b(fb_w[3]), .fail_op(fop_w[3]),
    .mismatch_cnt(cnt_w[3]));
  alu_mutation_scanner u4 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[4]), .done(done_w[4]),
    .killed(killed_w[4]), .alu_a(a_w[4]), .alu_b(b_w[4]), .alu_op(op_w[4]), .alu_result(res_w[4]),
    .alu_zero(zero_w[4]), .fail_a(fa_w[4]), .fail_b(fb_w[4]), .fail_op(fop_w[4]), .mismatch_cnt(cnt_w[4]));
  alu_mutation_scanner #(.SETTLE(2)) u5 (.clk(clk), .rst(rst5), .start(start5), .busy(busy_w[5]),
    .done(done_w[5]), .killed(killed_w[5]), .alu_a(a_w[5]), .alu_b(b_w[5]), .alu_op(op_w[5]),
    .alu_result(res_w[5]), .alu_zero(zero_w[5]), .fail_a(fa_w[5]), .fail_b(fb_w[5]), .fail_op(fop_w[5]),
    .mismatch_cnt(cnt_w[5]));
  alu_mutation_scanner #(.OPMASK(8'h00)) u6 (.clk(clk), .rst(rst), .start(start), .busy(busy_w[6]),
    .done(done_w[6]), .killed(killed_w[6]), .alu_a(a_w[6]), .alu_b(b_w[6]), .alu_op(op_w[6]),
    .alu_result(res_w[6]), .alu_zero(zero_w[6]), .fail_a(fa_w[6]), .fail_b(fb_w[6]), .fail_op(fop_w[6]),
    .mismatch_cnt(cnt_w[6]));

  typedef struct {
    int          done_cyc;
    logic        killed;
    int          cnt;
    logic [10:0] fail;
  } exp_t;

  exp_t        tab[NI];
  int          total = 0;
  int          bad   = 0;
  int          done_at[NI], done_n[NI], busy_n[NI];
  logic        seen_op0;
  logic [10:0] sb[$];
  logic [10:0] exp_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] all_outs(input int i);
    return {27'd0, busy_w[i], done_w[i], killed_w[i], a_w[i], b_w[i], op_w[i],
            fa_w[i], fb_w[i], fop_w[i], cnt_w[i]};
  endfunction

  initial begin
    tab[0] = '{2049, 1'b0, 0,   11'h000};
    tab[1] = '{3,    1'b1, 1,   11'h001};
    tab[2] = '{2049, 1'b1, 240, 11'h001};
    tab[3] = '{1793, 1'b0, 0,   11'h000};
`ifdef ALU_SCAN_ZERO_CHECK_EN
    tab[4] = '{2,    1'b1, 1,   11'h000};
`else
    tab[4] = '{2049, 1'b0, 0,   11'h000};
`endif
    tab[5] = '{12 + 6145, 1'b0, 0, 11'h000};
    tab[6] = '{1,    1'b0, 0,   11'h000};

    for (int i = 0; i < NI; i++) begin
      done_at[i] = 0;
      done_n[i]  = 0;
      busy_n[i]  = 0;
    end
    seen_op0 = 1'b0;

    rst = 1'b1; rst5 = 1'b1; start = 1'b0; start5 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst5 = 1'b0;
    @(negedge clk);
    check("reset_u0", all_outs(0), 64'd0);
    check("reset_u6", all_outs(6), 64'd0);

    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          sb.push_back({3'(op), 4'(a), 4'(b)});

    start = 1'b1; start5 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start5 = 1'b0;

    for (int cyc = 1; cyc <= 6200; cyc++) begin
      @(negedge clk);
      if (cyc == 10) rst5 = 1'b1;
      if (cyc == 11) begin
        rst5 = 1'b0;
        check("rst_midscan_u5", all_outs(5), 64'd0);
      end
      if (cyc == 12) start5 = 1'b1;
      if (cyc == 13) start5 = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (done_w[i]) begin
          done_n[i]++;
          if (done_at[i] == 0) done_at[i] = cyc;
        end
        if (busy_w[i]) busy_n[i]++;
      end
      if (busy_w[0]) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_vec = sb.pop_front();
          check($sformatf("vec_u0_c%0d", cyc), 64'({op_w[0], a_w[0], b_w[0]}), 64'(exp_vec));
        end
      end
      if (busy_w[3] && op_w[3] == 3'd0) seen_op0 = 1'b1;
    end

    for (int i = 0; i < NI; i++) begin
      check($sformatf("done_cycle_u%0d", i), 64'(done_at[i]), 64'(tab[i].done_cyc));
      check($sformatf("done_pulses_u%0d", i), 64'(done_n[i]), 64'd1);
      check($sformatf("killed_u%0d", i), 64'(killed_w[i]), 64'(tab[i].killed));
      check($sformatf("mismatch_cnt_u%0d", i), 64'(cnt_w[i]), 64'(tab[i].cnt));
      check($sformatf("fail_vec_u%0d", i), 64'({fop_w[i], fa_w[i], fb_w[i]}), 64'(tab[i].fail));
      check($sformatf("busy_idle_u%0d", i), 64'(busy_w[i]), 64'd0);
    end
    check("busy_cycles_u0", 64'(busy_n[0]), 64'd2048);
    check("busy_cycles_u6", 64'(busy_n[6]), 64'd0);
    check("sb_leftover_u0", 64'(sb.size()), 64'd0);
    check("op0_seen_u3", 64'(seen_op0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mutation_scanner.md
Name: alu_mutation_scanner

Overview:
- Sequencer that exhaustively drives an external 4-bit ALU under test, which may be a mutant, through every enabled opcode and all A/B operand pairs.
- Compares each ALU response against an internal golden model.
- Reports whether the mutant is killed, the first failing vector, and the total mismatch count.
- Sits in the mutation-testing harness between the test controller (start/done) and the combinational ALU under test.

Parameters:
- SETTLE, 0, extra cycles each vector is held before sampling (legal 0..7); each vector occupies SETTLE+1 cycles.
- OPMASK, 8'hFF, bit i set means opcode i is swept; cleared opcodes are skipped in zero cycles.
- STOP_ON_KILL, 1, 1 ends the scan at the first mismatch; 0 sweeps everything and counts all mismatches.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse at scan end.
- killed  out  1  at least one mismatch in the last scan; holds until next start.
- alu_a  out  4  operand A to ALU under test (registered).
- alu_b  out  4  operand B to ALU under test (registered).
- alu_op  out  3  opcode to ALU under test (registered).
- alu_result  in  4  ALU under test result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU under test zero flag.
- fail_a  out  4  A of the first mismatch.
- fail_b  out  4  B of the first mismatch.
- fail_op  out  3  opcode of the first mismatch.
- mismatch_cnt  out  12  number of mismatching vectors in the last scan.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-scan aborts the scan; no done pulse is produced.
- FSM states: IDLE, SCAN, FIN.
- IDLE, start=1: clear killed, fail_*, mismatch_cnt and the settle counter.
  - Load the first vector: lowest enabled opcode, A=0, B=0.
  - Go to SCAN with busy=1.
  - If OPMASK==0, go directly to FIN.
- start while busy or in FIN is ignored.
- Vector order: {op, A, B} ascending. B is the innermost loop, then A, then op. Disabled opcodes are skipped with no wasted cycle.
- SCAN: vector outputs are stable for SETTLE+1 cycles. On the last of those cycles:
  - Compare alu_result against the golden result for the current alu_op/alu_a/alu_b.
  - On mismatch: increment mismatch_cnt and set killed. If killed was previously 0, capture fail_* from the current vector.
  - Then advance to the next vector. If the vector was the last enabled one, go to FIN.
  - If a mismatch occurs and STOP_ON_KILL=1, go to FIN instead of advancing.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. alu_* hold their last value until the next start.
- Latency: the first vector appears the cycle after the start edge. With no early stop, done is asserted in cycle N*(SETTLE+1)+1 after the start edge, where N = popcount(OPMASK)*256.
- Golden model:
  - 000 ADD: (A+B) mod 16.
  - 001 SUB: (A-B) mod 16.
  - 010 AND, 011 OR, 100 XOR.
  - 101 EQ: 1 if A==B else 0.
  - 110 LT: unsigned, 1 if A<B else 0.
  - 111: result 0.
- mismatch_cnt maximum is 2048, which fits in 12 bits; no saturation logic is required.

Optional Feature:
- Macro ALU_SCAN_ZERO_CHECK_EN.
- When defined: a vector also mismatches if alu_zero != (golden result == 0).
- When undefined: alu_zero is ignored and only alu_result is compared.

Decomposition:
- Package alu_scan_pkg holds:
  - opcode localparams OP_ADD..OP_NOP;
  - the FSM state enum (IDLE/SCAN/FIN);
  - vector width constants (4-bit operand, 3-bit opcode, 11-bit vector index).
- One sub-module, alu_golden_model: combinational, A/B/op in, expected result and expected zero out. It is instanced once inside the scanner.

Test Plan:
- Correct ALU, defaults: start at cycle 0 -> done at cycle 2049, killed=0, mismatch_cnt=0, busy high cycles 1..2048.
- Mutant with ADD computing B+B, STOP_ON_KILL=1:
  - A=0,B=0 passes.
  - A=0,B=1 fails (2 vs 1).
  - Expected: fail_op=000, fail_a=0, fail_b=1, killed=1, done at cycle 3.
- Same mutant, STOP_ON_KILL=0: mismatch on every pair with A!=B -> mismatch_cnt=240, fail_* = 000/0/1, done at cycle 2049.
- Same mutant, OPMASK=8'hFE: ADD is skipped -> killed=0, done at cycle 1793, alu_op never shows 000.
- Zero flag stuck at 0, ALU_SCAN_ZERO_CHECK_EN defined -> first vector fails: fail_op=000, fail_a=0, fail_b=0, done at cycle 2. Macro undefined -> killed=0.
- SETTLE=2 with rst pulsed at cycle 10 -> all outputs 0 at cycle 11, no done pulse. A new start then gives a correct ALU done at cycle 6145.
